// File: rtl/rrc_rdseq.sv
// rrc_rdseq: read sequencer for the rrc ReRAM macro.
// Takes single-beat read requests, runs the macro through the wake, setup,
// sense and recover phases, and returns the captured data as a one-cycle
// response. Puts the macro into NAP after a programmable idle period.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request, idle counter may push the macro to NAP
// WAKE    | NAP released, waiting T_WAKE cycles before driving enables
// SETUP   | CE/XE/YE and address driven for T_SETUP cycles
// SENSE   | AE/READ driven, waiting for RDONE or TMO_CYC cycles
// RESP    | one-cycle response pulse, all strobes low
// RECOVER | all strobes low for T_REC cycles before the next accept
module rrc_rdseq #(
    parameter int XAW      = 12,
    parameter int YAW      = 5,
    parameter int DW       = 144,
    parameter int T_SETUP  = 2,
    parameter int T_REC    = 1,
    parameter int T_WAKE   = 4,
    parameter int TMO_CYC  = 64,
    parameter int NAP_IDLE = 256,
    parameter int CW       = 16
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           cfg_en,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [XAW-1:0] req_xadr,
    input  logic [YAW-1:0] req_yadr,
    output logic           rsp_valid,
    output logic           rsp_err,
    output logic [DW-1:0]  rsp_data,
    output logic           busy,
    output logic           CE,
    output logic           XE,
    output logic           YE,
    output logic           AE,
    output logic           READ,
    output logic           NAP,
    output logic [XAW-1:0] XADR,
    output logic [YAW-1:0] YADR,
    input  logic           RDONE,
    input  logic [DW-1:0]  DOUT
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAKE    = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_SENSE   = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;
    localparam logic [2:0] S_RECOVER = 3'd5;

    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_WAKE  = CW'(T_WAKE);
    localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP);
    localparam logic [CW-1:0] C_TMO   = CW'(TMO_CYC);
    localparam logic [CW-1:0] C_REC   = CW'(T_REC);
    // Idle count at which NAP is requested; unused when auto-nap is off.
    localparam logic [CW-1:0] C_NAP   = CW'((NAP_IDLE > 0) ? (NAP_IDLE - 1) : 0);
    localparam bit            NAP_ON  = (NAP_IDLE > 0);

    logic [2:0]     r_state;
    logic [2:0]     w_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [CW-1:0]  r_idle_cnt;
    logic           r_rdy;
    logic           r_en;
    logic           r_sense;
    logic           r_nap;
    logic           r_busy;
    logic           r_rsp_valid;
    logic           r_rsp_err;
    logic [DW-1:0]  r_rsp_data;
    logic [XAW-1:0] r_xadr;
    logic [YAW-1:0] r_yadr;
    logic           w_accept;
    logic           w_tmo;
    logic           w_hit;
    logic           w_idle_inc;

    // r_rdy only marks "state is IDLE"; cfg_en gates it so a drop of
    // cfg_en blocks the very next accept.
    assign req_ready  = r_rdy & cfg_en;
    assign w_accept   = req_valid & req_ready;
    assign w_hit      = (r_state == S_SENSE) & RDONE;
    assign w_tmo      = (r_state == S_SENSE) & ~RDONE & (r_cnt == C_TMO);
    assign w_idle_inc = NAP_ON & (r_state == S_IDLE) & ~w_accept & ~r_nap & cfg_en;

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;
    assign CE        = r_en;
    assign XE        = r_en;
    assign YE        = r_en;
    assign AE        = r_sense;
    assign READ      = r_sense;
    assign NAP       = r_nap;
    assign XADR      = r_xadr;
    assign YADR      = r_yadr;

    // Next state and phase counter; the counter reads 1 in the first cycle
    // of each timed phase.
    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    w_nxt     = r_nap ? S_WAKE : S_SETUP;
                    w_cnt_nxt = C_ONE;
                end
            end
            S_WAKE: begin
                if (r_cnt == C_WAKE) begin
                    w_nxt     = S_SETUP;
                    w_cnt_nxt = C_ONE;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_SETUP: begin
                if (r_cnt == C_SETUP) begin
                    w_nxt     = S_SENSE;
                    w_cnt_nxt = C_ONE;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_SENSE: begin
                if (w_hit || w_tmo) begin
                    w_nxt     = S_RESP;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_RESP: begin
                w_nxt     = S_RECOVER;
                w_cnt_nxt = C_ONE;
            end
            S_RECOVER: begin
                if (r_cnt == C_REC) begin
                    w_nxt     = S_IDLE;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            default: begin
                w_nxt     = S_IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // State, counter and registered macro/response outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rdy       <= 1'b0;
            r_en        <= 1'b0;
            r_sense     <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_xadr      <= '0;
            r_yadr      <= '0;
        end else begin
            r_state     <= w_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rdy       <= (w_nxt == S_IDLE);
            r_en        <= (w_nxt == S_SETUP) || (w_nxt == S_SENSE);
            r_sense     <= (w_nxt == S_SENSE);
            r_busy      <= (w_nxt != S_IDLE);
            r_rsp_valid <= (w_nxt == S_RESP);
            r_rsp_err   <= w_tmo;
            if (w_hit) begin
                r_rsp_data <= DOUT;
            end else if (w_tmo) begin
                r_rsp_data <= '0;
            end
            if (w_accept) begin
                r_xadr <= req_xadr;
                r_yadr <= req_yadr;
            end
        end
    end

    // Idle counter and NAP; an accept always beats a NAP request in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idle_cnt <= '0;
            r_nap      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_nap <= 1'b0;
            end
            if (w_idle_inc) begin
                if (r_idle_cnt == C_NAP) begin
                    r_idle_cnt <= '0;
                    r_nap      <= 1'b1;
                end else begin
                    r_idle_cnt <= r_idle_cnt + C_ONE;
                end
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rrc_rdseq.sv
// Testbench for rrc_rdseq: directed scenarios plus randomized reads checked
// against a phase-timeline model of the read sequence and idle/NAP timer.
module tb_rrc_rdseq;

    localparam int XAW      = 12;
    localparam int YAW      = 5;
    localparam int DW       = 144;
    localparam int T_SETUP  = 2;
    localparam int T_REC    = 1;
    localparam int T_WAKE   = 4;
    localparam int TMO_CYC  = 64;
    localparam int NAP_IDLE = 8;

    // {busy, NAP, CE, XE, YE, AE, READ, rsp_valid, rsp_err}
    localparam logic [8:0] V_IDLE  = 9'b0_0_00000_0_0;
    localparam logic [8:0] V_NAP   = 9'b0_1_00000_0_0;
    localparam logic [8:0] V_WAKE  = 9'b1_0_00000_0_0;
    localparam logic [8:0] V_SETUP = 9'b1_0_11100_0_0;
    localparam logic [8:0] V_SENSE = 9'b1_0_11111_0_0;
    localparam logic [8:0] V_REC   = 9'b1_0_00000_0_0;

    logic           clk;
    logic           resetn;
    logic           cfg_en;
    logic           req_valid;
    logic           req_ready;
    logic [XAW-1:0] req_xadr;
    logic [YAW-1:0] req_yadr;
    logic           rsp_valid;
    logic           rsp_err;
    logic [DW-1:0]  rsp_data;
    logic           busy;
    logic           CE, XE, YE, AE, READ, NAP;
    logic [XAW-1:0] XADR;
    logic [YAW-1:0] YADR;
    logic           RDONE;
    logic [DW-1:0]  DOUT;
    logic [8:0]     obs;

    int             n_checks = 0;
    int             n_pass   = 0;
    bit             exp_nap;
    int             idle_k;
    logic [DW-1:0]  exp_data;

    rrc_rdseq #(
        .XAW(XAW), .YAW(YAW), .DW(DW), .T_SETUP(T_SETUP), .T_REC(T_REC),
        .T_WAKE(T_WAKE), .TMO_CYC(TMO_CYC), .NAP_IDLE(NAP_IDLE), .CW(16)
    ) dut (
        .clk(clk), .resetn(resetn), .cfg_en(cfg_en), .req_valid(req_valid),
        .req_ready(req_ready), .req_xadr(req_xadr), .req_yadr(req_yadr),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .busy(busy), .CE(CE), .XE(XE), .YE(YE), .AE(AE), .READ(READ),
        .NAP(NAP), .XADR(XADR), .YADR(YADR), .RDONE(RDONE), .DOUT(DOUT)
    );

    assign obs = {busy, NAP, CE, XE, YE, AE, READ, rsp_valid, rsp_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle in IDLE; try_req raises req_valid (only meaningful with en=0).
    task automatic idle_step(input bit en, input bit try_req);
        cfg_en    = en;
        req_valid = try_req;
        RDONE     = 1'($urandom_range(0, 1));
        DOUT      = rand_data();
        #1;
        n_checks++;
        if (obs !== (exp_nap ? V_NAP : V_IDLE))
            $display("FAIL idle_vec: got %b want %b", obs, exp_nap ? V_NAP : V_IDLE);
        else n_pass++;
        n_checks++;
        if (rsp_data !== exp_data)
            $display("FAIL idle_data_hold: got %h want %h", rsp_data, exp_data);
        else n_pass++;
        if (!en) begin
            n_checks++;
            if (req_ready !== 1'b0)
                $display("FAIL idle_ready_blocked: got %b want 0", req_ready);
            else n_pass++;
        end
        if (en && !exp_nap) begin
            idle_k++;
            if (idle_k == NAP_IDLE) begin
                exp_nap = 1'b1;
                idle_k  = 0;
            end
        end else begin
            idle_k = 0;
        end
        tick();
        req_valid = 1'b0;
    endtask

    // Full read starting in an IDLE cycle; returns in the first IDLE cycle after.
    // delay = SENSE cycle in which RDONE is driven (outside 1..TMO_CYC: never).
    task automatic do_read(input logic [XAW-1:0] x, input logic [YAW-1:0] y,
                           input int delay, input logic [DW-1:0] data,
                           input bit hold, input logic [XAW-1:0] nx,
                           input logic [YAW-1:0] ny);
        int  wake;
        bit  tmo;
        bit  rd;
        tmo       = (delay < 1) || (delay > TMO_CYC);
        cfg_en    = 1'b1;
        req_valid = 1'b1;
        req_xadr  = x;
        req_yadr  = y;
        RDONE     = 1'($urandom_range(0, 1));
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL accept_ready: got %b want 1", req_ready);
        else n_pass++;
        n_checks++;
        if (obs !== (exp_nap ? V_NAP : V_IDLE))
            $display("FAIL accept_vec: got %b want %b", obs, exp_nap ? V_NAP : V_IDLE);
        else n_pass++;
        wake    = exp_nap ? T_WAKE : 0;
        exp_nap = 1'b0;
        idle_k  = 0;
        tick();
        if (hold) begin
            req_xadr = nx;
            req_yadr = ny;
        end else begin
            req_valid = 1'b0;
        end
        for (int i = 0; i < wake; i++) begin
            RDONE = 1'($urandom_range(0, 1));
            n_checks++;
            if (obs !== V_WAKE) $display("FAIL wake_vec: got %b want %b", obs, V_WAKE);
            else n_pass++;
            tick();
        end
        for (int i = 0; i < T_SETUP; i++) begin
            RDONE  = 1'($urandom_range(0, 1));
            cfg_en = 1'($urandom_range(0, 1));
            n_checks++;
            if (obs !== V_SETUP) $display("FAIL setup_vec: got %b want %b", obs, V_SETUP);
            else n_pass++;
            n_checks++;
            if ({XADR, YADR} !== {x, y})
                $display("FAIL setup_addr: got %h/%h want %h/%h", XADR, YADR, x, y);
            else n_pass++;
            tick();
        end
        for (int s = 1; s <= TMO_CYC; s++) begin
            rd     = (s == delay);
            RDONE  = rd;
            DOUT   = rd ? data : rand_data();
            cfg_en = 1'($urandom_range(0, 1));
            n_checks++;
            if (obs !== V_SENSE) $display("FAIL sense_vec: cyc %0d got %b want %b", s, obs, V_SENSE);
            else n_pass++;
            tick();
            if (rd) break;
        end
        exp_data = tmo ? '0 : data;
        RDONE    = 1'($urandom_range(0, 1));
        DOUT     = rand_data();
        n_checks++;
        if (obs !== {1'b1, 1'b0, 5'b0, 1'b1, tmo})
            $display("FAIL resp_vec: got %b want %b", obs, {1'b1, 1'b0, 5'b0, 1'b1, tmo});
        else n_pass++;
        n_checks++;
        if (rsp_data !== exp_data) $display("FAIL resp_data: got %h want %h", rsp_data, exp_data);
        else n_pass++;
        tick();
        for (int i = 0; i < T_REC; i++) begin
            RDONE = 1'($urandom_range(0, 1));
            n_checks++;
            if (obs !== V_REC) $display("FAIL recover_vec: got %b want %b", obs, V_REC);
            else n_pass++;
            n_checks++;
            if (rsp_data !== exp_data) $display("FAIL recover_data: got %h want %h", rsp_data, exp_data);
            else n_pass++;
            tick();
        end
        RDONE  = 1'b0;
        idle_k = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; cfg_en = 1'b1; req_valid = 1'b0; req_xadr = '0; req_yadr = '0;
        RDONE = 1'b0; DOUT = '0;
        #22;
        n_checks++;
        if (obs !== 9'b0) $display("FAIL reset_vec: got %b want 0", obs);
        else n_pass++;
        n_checks++;
        if ({req_ready, rsp_data, XADR, YADR} !== '0)
            $display("FAIL reset_misc: got rdy=%b data=%h x=%h y=%h want 0", req_ready, rsp_data, XADR, YADR);
        else n_pass++;
        #1 resetn = 1'b1;
        exp_nap = 1'b0; idle_k = 0; exp_data = '0;
    endtask

    task automatic test_single();
        idle_step(1'b1, 1'b0);
        idle_step(1'b1, 1'b0);
        do_read(12'h123, 5'h0A, 3, {18{8'hA5}}, 1'b0, '0, '0);
    endtask

    task automatic test_timeout();
        do_read(12'h456, 5'h15, 1000, rand_data(), 1'b0, '0, '0);
        cfg_en = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL tmo_ready_after: got %b want 1", req_ready);
        else n_pass++;
        do_read(12'h789, 5'h03, TMO_CYC, rand_data(), 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back();
        do_read(12'hFFF, 5'h1F, 1, rand_data(), 1'b1, 12'h000, 5'h00);
        do_read(12'h000, 5'h00, 1, rand_data(), 1'b0, '0, '0);
        n_checks++;
        if ({XADR, YADR} !== 17'h0) $display("FAIL b2b_addr_hold: got %h/%h want 0/0", XADR, YADR);
        else n_pass++;
    endtask

    task automatic test_nap();
        for (int i = 0; i < NAP_IDLE; i++) idle_step(1'b1, 1'b0);
        n_checks++;
        if (NAP !== 1'b1) $display("FAIL nap_assert: got %b want 1", NAP);
        else n_pass++;
        do_read(12'h0F0, 5'h11, 2, rand_data(), 1'b0, '0, '0);
        for (int i = 0; i < NAP_IDLE; i++) idle_step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle_step(1'b0, 1'b1);
        n_checks++;
        if (NAP !== 1'b1) $display("FAIL nap_hold_cfg_off: got %b want 1", NAP);
        else n_pass++;
        do_read(12'h00F, 5'h01, 4, rand_data(), 1'b0, '0, '0);
    endtask

    task automatic test_nap_race();
        for (int i = 0; i < NAP_IDLE - 1; i++) idle_step(1'b1, 1'b0);
        do_read(12'hABC, 5'h07, 1, rand_data(), 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid();
        cfg_en = 1'b1; req_valid = 1'b1; req_xadr = 12'h321; req_yadr = 5'h09; RDONE = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < T_SETUP + 1; i++) tick();
        n_checks++;
        if (obs !== V_SENSE) $display("FAIL rst_mid_in_sense: got %b want %b", obs, V_SENSE);
        else n_pass++;
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({obs, rsp_data, XADR, YADR} !== '0)
            $display("FAIL rst_mid_async: got vec=%b data=%h x=%h y=%h want 0", obs, rsp_data, XADR, YADR);
        else n_pass++;
        @(posedge clk);
        #3 resetn = 1'b1;
        exp_nap = 1'b0; idle_k = 0; exp_data = '0;
        for (int i = 0; i < 3; i++) idle_step(1'b1, 1'b0);
        do_read(12'h5A5, 5'h1A, 2, rand_data(), 1'b0, '0, '0);
    endtask

    task automatic test_random();
        int gap;
        int r;
        int dly;
        bit en;
        for (int n = 0; n < 30; n++) begin
            gap = $urandom_range(0, 12);
            for (int g = 0; g < gap; g++) begin
                en = ($urandom_range(0, 3) != 0);
                idle_step(en, !en && ($urandom_range(0, 1) != 0));
            end
            r = $urandom_range(0, 9);
            if (r < 6)      dly = $urandom_range(1, 6);
            else if (r < 8) dly = $urandom_range(60, TMO_CYC);
            else            dly = 100;
            do_read(XAW'($urandom), YAW'($urandom), dly, rand_data(), 1'b0, '0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_back_to_back();
        test_nap();
        test_nap_race();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
